eth_rx_frame_ctrl: RTL and testbench

Receive-frame controller behind the Ethernet nibble-to-byte converter. Takes the converted byte stream, the frame envelope and the conversion-error flag, and writes each frame into one of 2^SLOT_BITS fixed-size slots of a shared receive RAM. Publishes length and status per committed frame to a downstream consumer through a ready/ack handshake. Drops frames when no slot is free, and discards runt and errored frames.

---
 rtl/eth_rx_frame_ctrl_if.sv | 22 ++
 rtl/eth_rx_frame_ctrl.sv | 153 +++++++++++++++
 tb/tb_eth_rx_frame_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_rx_frame_ctrl_if.sv
// Frame descriptor handshake between the receive controller and its consumer.
// master: controller (ready/slot/len/err out, ack in); slave: consumer.
interface eth_rx_frame_ctrl_if #(
   parameter int SLOT_BITS = 2,
   parameter int SLOT_AW   = 11
);
   logic                 frame_ready;
   logic [SLOT_BITS-1:0] frame_slot;
   logic [SLOT_AW-1:0]   frame_len;
   logic                 frame_err;
   logic                 frame_ack;

   modport master (
      output frame_ready, frame_slot, frame_len, frame_err,
      input  frame_ack
   );

   modport slave (
      input  frame_ready, frame_slot, frame_len, frame_err,
      output frame_ack
   );
endinterface

// File: rtl/eth_rx_frame_ctrl.sv
// Receive-frame controller: writes converted bytes into RAM slots, commits
// good frames as descriptors, drops frames when all slots are busy.
// Ports: clock/reset (sync, active-high); rx_* byte stream and envelope in;
// ram_* registered write port out; fr = descriptor handshake (master);
// drop_cnt = saturating count of frames dropped for lack of a slot.
// Option: define ETH_RX_KEEP_BAD_EN to commit errored/long frames, flagged.
module eth_rx_frame_ctrl #(
   parameter int SLOT_BITS = 2,
   parameter int SLOT_AW   = 11,
   parameter int MIN_LEN   = 64,
   parameter int MAX_LEN   = 1518
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [7:0]                   rx_data,
   input  logic                         rx_wren,
   input  logic                         rx_active,
   input  logic                         rx_error,
   output logic                         ram_we,
   output logic [SLOT_BITS+SLOT_AW-1:0] ram_waddr,
   output logic [7:0]                   ram_wdata,
   eth_rx_frame_ctrl_if.master          fr,
   output logic [15:0]                  drop_cnt
);

   localparam int NSLOT = 1 << SLOT_BITS;
   localparam logic [SLOT_AW-1:0] MIN_L = SLOT_AW'(MIN_LEN);
   localparam logic [SLOT_AW-1:0] MAX_L = SLOT_AW'(MAX_LEN);
   localparam logic [SLOT_BITS:0] FULL  = (SLOT_BITS+1)'(NSLOT);

   typedef enum logic [2:0] {
      IDLE, RECV, CLOSE0, CLOSE1, DROP
   } state_t;

   state_t               state;
   state_t               next;
   logic                 post_rst;
   logic [SLOT_AW-1:0]   byte_cnt;
   logic                 err_q;
   logic                 long_q;
   logic [SLOT_BITS-1:0] wr_ptr;
   logic [SLOT_BITS-1:0] rd_ptr;
   logic [SLOT_BITS:0]   count;
   logic [SLOT_AW-1:0]   len_q [NSLOT];

   logic full;
   logic start;
   logic drop_inc;
   logic wr_en;
   logic err_in;
   logic commit;
   logic ack;

   assign full   = (count == FULL);
   // converter flags arrive late, so CLOSE1 sees the live flag too
   assign err_in = err_q | rx_error;
   assign wr_en  = (state == RECV) && rx_wren && (byte_cnt < MAX_L);
   assign ack    = fr.frame_ack && (count != '0);

`ifdef ETH_RX_KEEP_BAD_EN
   logic bad_q [NSLOT];

   assign commit = (state == CLOSE1) && (byte_cnt >= MIN_L);
   assign fr.frame_err = (count != '0) && bad_q[rd_ptr];

   always_ff @(posedge clock) begin
      if (commit) bad_q[wr_ptr] <= err_in | long_q;
   end
`else
   assign commit = (state == CLOSE1) && (byte_cnt >= MIN_L)
                   && !err_in && !long_q;
   assign fr.frame_err = 1'b0;
`endif

   assign fr.frame_ready = (count != '0);
   assign fr.frame_slot  = rd_ptr;
   assign fr.frame_len   = (count != '0) ? len_q[rd_ptr] : '0;

   // a frame already in flight when reset lifts is skipped uncounted
   always_comb begin
      next     = state;
      start    = 1'b0;
      drop_inc = 1'b0;
      unique case (state)
         IDLE: begin
            if (rx_active) begin
               if (post_rst || full) begin
                  next     = DROP;
                  drop_inc = !post_rst;
               end else begin
                  next  = RECV;
                  start = 1'b1;
               end
            end
         end
         RECV:    if (!rx_active) next = CLOSE0;
         CLOSE0:  next = CLOSE1;
         CLOSE1:  next = IDLE;
         DROP:    if (!rx_active) next = IDLE;
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= next;
   end

   always_ff @(posedge clock) begin
      if (commit) len_q[wr_ptr] <= byte_cnt;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         post_rst  <= 1'b1;
         ram_we    <= 1'b0;
         ram_waddr <= '0;
         ram_wdata <= '0;
         byte_cnt  <= '0;
         err_q     <= 1'b0;
         long_q    <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         drop_cnt  <= '0;
      end else begin
         post_rst <= 1'b0;
         ram_we   <= wr_en;
         if (wr_en) begin
            ram_waddr <= {wr_ptr, byte_cnt};
            ram_wdata <= rx_data;
         end
         if (start) begin
            byte_cnt <= '0;
            err_q    <= 1'b0;
            long_q   <= 1'b0;
         end else begin
            if (wr_en) byte_cnt <= byte_cnt + 1'b1;
            if ((state == RECV) && rx_wren && !(byte_cnt < MAX_L))
               long_q <= 1'b1;
            if ((state == RECV) || (state == CLOSE0))
               err_q <= err_in;
         end
         if (drop_inc && (drop_cnt != 16'hFFFF))
            drop_cnt <= drop_cnt + 16'd1;
         if (commit) wr_ptr <= wr_ptr + 1'b1;
         if (ack)    rd_ptr <= rd_ptr + 1'b1;
         if (commit && !ack)      count <= count + 1'b1;
         else if (ack && !commit) count <= count - 1'b1;
      end
   end

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Randomized self-checking bench for eth_rx_frame_ctrl against a
// frame-level reference model (descriptor queue + expected write list).
module tb_eth_rx_frame_ctrl;

   localparam int NSLOT   = 4;
   localparam int MIN_LEN = 64;
   localparam int MAX_LEN = 1518;

   typedef struct {
      int slot;
      int len;
      bit err;
   } desc_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_wren = 1'b0;
   logic        rx_active = 1'b0;
   logic        rx_error = 1'b0;
   logic        ram_we;
   logic [12:0] ram_waddr;
   logic [7:0]  ram_wdata;
   logic [15:0] drop_cnt;

   eth_rx_frame_ctrl_if #(.SLOT_BITS(2), .SLOT_AW(11)) fif ();

   eth_rx_frame_ctrl dut (
      .clock     (clock),
      .reset     (reset),
      .rx_data   (rx_data),
      .rx_wren   (rx_wren),
      .rx_active (rx_active),
      .rx_error  (rx_error),
      .ram_we    (ram_we),
      .ram_waddr (ram_waddr),
      .ram_wdata (ram_wdata),
      .fr        (fif),
      .drop_cnt  (drop_cnt)
   );

   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_pass = 0;

   desc_t       q[$];
   logic [31:0] wq[$];
   int          wr_m   = 0;
   int          drop_m = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   always @(negedge clock) begin
      logic [31:0] e;
      if (ram_we) begin
         if (wq.size() == 0) begin
            chk("ram_we_extra", 32'd1, 32'd0);
         end else begin
            e = wq.pop_front();
            chk("ram_wr", {11'd0, ram_waddr, ram_wdata}, e);
         end
      end
   end

   task automatic check_outs(input string tag);
      chk({tag, "_ready"}, fif.frame_ready, q.size() != 0);
      if (q.size() != 0) begin
         chk({tag, "_slot"}, fif.frame_slot, q[0].slot);
         chk({tag, "_len"}, fif.frame_len, q[0].len);
         chk({tag, "_err"}, fif.frame_err, q[0].err);
      end
      chk({tag, "_drop"}, drop_cnt, drop_m);
   endtask

   task automatic do_reset();
      rx_active = 1'b0;
      rx_wren   = 1'b0;
      reset     = 1'b1;
      tick();
      reset = 1'b0;
      q.delete();
      wr_m   = 0;
      drop_m = 0;
      tick();
      chk("rst_ram_we", ram_we, 0);
      chk("rst_waddr", ram_waddr, 0);
      chk("rst_wdata", ram_wdata, 0);
      chk("rst_len", fif.frame_len, 0);
      chk("rst_slot", fif.frame_slot, 0);
      chk("rst_err", fif.frame_err, 0);
      check_outs("rst");
   endtask

   task automatic do_ack();
      fif.frame_ack = 1'b1;
      tick();
      fif.frame_ack = 1'b0;
      if (q.size() != 0) void'(q.pop_front());
      check_outs("ack");
   endtask

   task automatic send_frame(input int len, input bit err_pulse,
                             input bit ack_commit);
      bit full;
      bit commit;
      bit bad;
      bit ackv;
      int stored;
      int n;
      full   = (q.size() == NSLOT);
      stored = (len > MAX_LEN) ? MAX_LEN : len;
      bad    = err_pulse || (len > MAX_LEN);
`ifdef ETH_RX_KEEP_BAD_EN
      commit = !full && (stored >= MIN_LEN);
`else
      commit = !full && (stored >= MIN_LEN) && !bad;
      bad    = 1'b0;
`endif
      if (full && drop_m < 65535) drop_m++;
      rx_active = 1'b1;
      tick();
      n = 0;
      while (n < len) begin
         rx_wren = ($urandom_range(3) != 0);
         rx_data = 8'($urandom);
         if (rx_wren) begin
            if (!full && n < MAX_LEN)
               wq.push_back((wr_m << 19) | (n << 8) | int'(rx_data));
            n++;
         end
         tick();
      end
      rx_wren   = 1'b0;
      rx_active = 1'b0;
      tick();
      if (err_pulse) rx_error = 1'b1;
      tick();
      rx_error = 1'b0;
      chk("pre_commit_ready", fif.frame_ready, q.size() != 0);
      ackv = ack_commit && (q.size() != 0);
      if (ack_commit) fif.frame_ack = 1'b1;
      tick();
      fif.frame_ack = 1'b0;
      if (ackv) void'(q.pop_front());
      if (commit) begin
         q.push_back('{wr_m, stored, bad});
         wr_m = (wr_m + 1) % NSLOT;
      end
      chk("wr_count", wq.size(), 0);
      check_outs("frame");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      fif.frame_ack = 1'b0;
      do_reset();

      send_frame(64, 0, 0);
      do_ack();
      do_ack();

      do_reset();
      send_frame(60, 0, 0);
      send_frame(100, 0, 0);
      do_ack();

      do_reset();
      for (int i = 0; i < 5; i++) send_frame(64, 0, 0);
      do_ack();
      send_frame(64, 0, 0);

      do_reset();
      send_frame(100, 1, 0);
      send_frame(1600, 0, 0);
      send_frame(MAX_LEN, 0, 0);
      send_frame(63, 0, 0);

      do_reset();
      send_frame(70, 0, 0);
      send_frame(80, 0, 0);
      send_frame(90, 0, 1);
      do_ack();
      do_ack();
      do_ack();

      do_reset();
      send_frame(64, 0, 0);
      rx_active = 1'b1;
      tick();
      for (int i = 0; i < 30; i++) begin
         rx_wren = 1'b1;
         rx_data = 8'($urandom);
         wq.push_back((wr_m << 19) | (i << 8) | int'(rx_data));
         tick();
      end
      rx_wren = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      q.delete();
      wr_m   = 0;
      drop_m = 0;
      chk("midrst_ram_we", ram_we, 0);
      check_outs("midrst");
      for (int i = 0; i < 40; i++) begin
         rx_wren = 1'b1;
         rx_data = 8'($urandom);
         tick();
      end
      rx_wren   = 1'b0;
      rx_active = 1'b0;
      tick();
      tick();
      tick();
      chk("midrst_writes", wq.size(), 0);
      check_outs("midrst_end");
      send_frame(64, 0, 0);

      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(9);
         if (r == 0)      send_frame($urandom_range(63, 40), 0, 0);
         else if (r == 1) send_frame(64, $urandom_range(5) == 0, 0);
         else if (r == 2) send_frame(63, 0, $urandom_range(1));
         else if (r == 3) send_frame($urandom_range(1519, 1518), 0, 0);
         else send_frame($urandom_range(300, 64), $urandom_range(5) == 0,
                         $urandom_range(3) == 0);
         if ($urandom_range(2) == 0) do_ack();
      end
      while (q.size() != 0) do_ack();
      do_ack();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
